// File: rtl/swu_sched_pkg.sv
// Shared types and geometry helpers for the sliding-window buffer scheduler.
package swu_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned DEF_FOLD      = 2;
    localparam int unsigned DEF_IFM_DIM   = 8;
    localparam int unsigned DEF_OFM_DIM   = 6;
    localparam int unsigned DEF_K         = 3;
    localparam int unsigned DEF_STRIDE    = 1;
    localparam int unsigned DEF_BUF_DEPTH = 64;

    // Derived geometry of the default configuration
    localparam int unsigned TOTAL_IN    = DEF_IFM_DIM * DEF_IFM_DIM * DEF_FOLD;
    localparam int unsigned ROW_STEP    = DEF_IFM_DIM * DEF_FOLD;
    localparam int unsigned COL_STEP    = DEF_STRIDE * DEF_FOLD;
    localparam int unsigned TOTAL_BEATS = DEF_OFM_DIM * DEF_OFM_DIM * DEF_K * DEF_K * DEF_FOLD;

    // Counter width for a 0..n-1 range, never narrower than one bit
    function automatic int unsigned f_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/swu_wrap_add.sv
// Modular address add: (i_base + i_step) mod DEPTH, both operands already below DEPTH.
module swu_wrap_add #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic [AW-1:0] i_base,
    input  logic [AW-1:0] i_step,
    output logic [AW-1:0] o_sum_c
);

    localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

    logic [AW:0] w_raw;
    logic [AW:0] w_sub;

    assign w_raw   = {1'b0, i_base} + {1'b0, i_step};
    assign w_sub   = w_raw - L_DEPTH;
    assign o_sum_c = (w_raw >= L_DEPTH) ? w_sub[AW-1:0] : w_raw[AW-1:0];

endmodule

// File: rtl/swu_window_scheduler.sv
// Address/flow controller for a circular sliding-window buffer RAM.
// Optional `SWU_SCHED_STATS_EN adds read-starve and write-block statistics outputs.
module swu_window_scheduler
    import swu_sched_pkg::*;
#(
    parameter int unsigned FOLD      = DEF_FOLD,
    parameter int unsigned IFM_DIM   = DEF_IFM_DIM,
    parameter int unsigned OFM_DIM   = DEF_OFM_DIM,
    parameter int unsigned K         = DEF_K,
    parameter int unsigned STRIDE    = DEF_STRIDE,
    parameter int unsigned BUF_DEPTH = DEF_BUF_DEPTH,
    parameter int unsigned AW        = $clog2(BUF_DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [AW-1:0] wr_addr,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [AW-1:0] rd_addr,
    output logic          rd_last,
    output logic          busy,
    output logic          frame_done
`ifdef SWU_SCHED_STATS_EN
    ,
    output logic [31:0]   stat_rd_starve,
    output logic [31:0]   stat_wr_block
`endif
);

    localparam int unsigned L_TOTAL_IN  = IFM_DIM * IFM_DIM * FOLD;
    localparam int unsigned L_ROW_STEP  = IFM_DIM * FOLD;
    localparam int unsigned L_COL_STEP  = STRIDE * FOLD;
    localparam int unsigned L_WROW_STEP = STRIDE * L_ROW_STEP;
    localparam int unsigned CW          = $clog2(L_TOTAL_IN + BUF_DEPTH + 1);
    localparam int unsigned FW          = f_bits(FOLD);
    localparam int unsigned KW          = f_bits(K);
    localparam int unsigned OW          = f_bits(OFM_DIM);

    localparam logic [CW-1:0] C_TOTAL_IN  = CW'(L_TOTAL_IN);
    localparam logic [CW-1:0] C_DEPTH     = CW'(BUF_DEPTH);
    localparam logic [CW-1:0] C_ROW_STEP  = CW'(L_ROW_STEP);
    localparam logic [CW-1:0] C_COL_STEP  = CW'(L_COL_STEP);
    localparam logic [CW-1:0] C_WROW_STEP = CW'(L_WROW_STEP);
    localparam logic [FW-1:0] C_C_MAX     = FW'(FOLD - 1);
    localparam logic [KW-1:0] C_K_MAX     = KW'(K - 1);
    localparam logic [OW-1:0] C_O_MAX     = OW'(OFM_DIM - 1);

    state_e        r_state;
    logic [CW-1:0] r_wr_count, r_rel_count;
    // Linear element indices: current beat, kernel-row base, window base, window-row base
    logic [CW-1:0] r_cur_lin, r_row_lin, r_win_lin, r_wrow_lin;
    logic [FW-1:0] r_c;
    logic [KW-1:0] r_kw, r_kh;
    logic [OW-1:0] r_ox, r_oy;
    logic [AW-1:0] r_wr_addr, r_rd_addr, r_row_addr, r_win_addr, r_wrow_addr;
    logic          r_wr_ready, r_rd_valid, r_rd_last, r_busy, r_frame_done;

    state_e        w_state_nxt;
    logic [CW-1:0] w_wr_count_nxt, w_rel_count_nxt;
    logic [CW-1:0] w_cur_lin_nxt, w_row_lin_nxt, w_win_lin_nxt, w_wrow_lin_nxt;
    logic [FW-1:0] w_c_nxt;
    logic [KW-1:0] w_kw_nxt, w_kh_nxt;
    logic [OW-1:0] w_ox_nxt, w_oy_nxt;
    logic [AW-1:0] w_wr_addr_nxt, w_rd_addr_nxt, w_row_addr_nxt, w_win_addr_nxt, w_wrow_addr_nxt;
    logic          w_wr_ready_nxt, w_rd_valid_nxt, w_rd_last_nxt;
    logic          w_wr_fire, w_rd_fire;

    logic [AW-1:0] w_wr_addr_inc, w_rd_addr_inc, w_row_addr_step, w_win_addr_step, w_wrow_addr_step;

    swu_wrap_add #(.DEPTH(BUF_DEPTH), .AW(AW)) u_wr_inc (
        .i_base (r_wr_addr),
        .i_step (AW'(1)),
        .o_sum_c(w_wr_addr_inc)
    );

    swu_wrap_add #(.DEPTH(BUF_DEPTH), .AW(AW)) u_rd_inc (
        .i_base (r_rd_addr),
        .i_step (AW'(1)),
        .o_sum_c(w_rd_addr_inc)
    );

    swu_wrap_add #(.DEPTH(BUF_DEPTH), .AW(AW)) u_row_step (
        .i_base (r_row_addr),
        .i_step (AW'(L_ROW_STEP)),
        .o_sum_c(w_row_addr_step)
    );

    swu_wrap_add #(.DEPTH(BUF_DEPTH), .AW(AW)) u_win_step (
        .i_base (r_win_addr),
        .i_step (AW'(L_COL_STEP)),
        .o_sum_c(w_win_addr_step)
    );

    swu_wrap_add #(.DEPTH(BUF_DEPTH), .AW(AW)) u_wrow_step (
        .i_base (r_wrow_addr),
        .i_step (AW'(L_WROW_STEP)),
        .o_sum_c(w_wrow_addr_step)
    );

    assign w_wr_fire = wr_valid & r_wr_ready;
    assign w_rd_fire = r_rd_valid & rd_ready;

    // Next-state, counter and registered-output computation
    always_comb begin
        w_state_nxt     = r_state;
        w_wr_count_nxt  = r_wr_count;
        w_rel_count_nxt = r_rel_count;
        w_cur_lin_nxt   = r_cur_lin;
        w_row_lin_nxt   = r_row_lin;
        w_win_lin_nxt   = r_win_lin;
        w_wrow_lin_nxt  = r_wrow_lin;
        w_c_nxt         = r_c;
        w_kw_nxt        = r_kw;
        w_kh_nxt        = r_kh;
        w_ox_nxt        = r_ox;
        w_oy_nxt        = r_oy;
        w_wr_addr_nxt   = r_wr_addr;
        w_rd_addr_nxt   = r_rd_addr;
        w_row_addr_nxt  = r_row_addr;
        w_win_addr_nxt  = r_win_addr;
        w_wrow_addr_nxt = r_wrow_addr;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt     = RUN;
                    w_wr_count_nxt  = '0;
                    w_rel_count_nxt = '0;
                    w_cur_lin_nxt   = '0;
                    w_row_lin_nxt   = '0;
                    w_win_lin_nxt   = '0;
                    w_wrow_lin_nxt  = '0;
                    w_c_nxt         = '0;
                    w_kw_nxt        = '0;
                    w_kh_nxt        = '0;
                    w_ox_nxt        = '0;
                    w_oy_nxt        = '0;
                    w_wr_addr_nxt   = '0;
                    w_rd_addr_nxt   = '0;
                    w_row_addr_nxt  = '0;
                    w_win_addr_nxt  = '0;
                    w_wrow_addr_nxt = '0;
                end
            end
            FLUSH: begin
                if (r_wr_count == C_TOTAL_IN) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = r_state;
        endcase

        if (w_wr_fire) begin
            w_wr_count_nxt = r_wr_count + 1'b1;
            w_wr_addr_nxt  = w_wr_addr_inc;
        end

        // Channel fold and kw are contiguous in memory, so both step by one element
        if (w_rd_fire) begin
            if (r_c != C_C_MAX || r_kw != C_K_MAX) begin
                w_c_nxt       = (r_c == C_C_MAX) ? '0 : r_c + 1'b1;
                w_kw_nxt      = (r_c == C_C_MAX) ? r_kw + 1'b1 : r_kw;
                w_cur_lin_nxt = r_cur_lin + 1'b1;
                w_rd_addr_nxt = w_rd_addr_inc;
            end else if (r_kh != C_K_MAX) begin
                w_c_nxt        = '0;
                w_kw_nxt       = '0;
                w_kh_nxt       = r_kh + 1'b1;
                w_row_lin_nxt  = r_row_lin + C_ROW_STEP;
                w_cur_lin_nxt  = r_row_lin + C_ROW_STEP;
                w_row_addr_nxt = w_row_addr_step;
                w_rd_addr_nxt  = w_row_addr_step;
            end else begin
                w_c_nxt  = '0;
                w_kw_nxt = '0;
                w_kh_nxt = '0;
                if (r_ox != C_O_MAX) begin
                    w_ox_nxt       = r_ox + 1'b1;
                    w_win_lin_nxt  = r_win_lin + C_COL_STEP;
                    w_win_addr_nxt = w_win_addr_step;
                end else begin
                    w_ox_nxt        = '0;
                    w_oy_nxt        = (r_oy == C_O_MAX) ? '0 : r_oy + 1'b1;
                    w_wrow_lin_nxt  = r_wrow_lin + C_WROW_STEP;
                    w_wrow_addr_nxt = w_wrow_addr_step;
                    w_win_lin_nxt   = r_wrow_lin + C_WROW_STEP;
                    w_win_addr_nxt  = w_wrow_addr_step;
                end
                w_row_lin_nxt  = w_win_lin_nxt;
                w_cur_lin_nxt  = w_win_lin_nxt;
                w_row_addr_nxt = w_win_addr_nxt;
                w_rd_addr_nxt  = w_win_addr_nxt;
                if (r_ox == C_O_MAX && r_oy == C_O_MAX) begin
                    w_rel_count_nxt = C_TOTAL_IN;
                    w_state_nxt     = FLUSH;
                end else begin
                    w_rel_count_nxt = w_win_lin_nxt;
                end
            end
        end

        // Occupancy test written as an add so a release past wr_count cannot underflow
        w_wr_ready_nxt = (w_state_nxt == RUN || w_state_nxt == FLUSH)
                         && (w_wr_count_nxt < w_rel_count_nxt + C_DEPTH)
                         && (w_wr_count_nxt < C_TOTAL_IN);
        w_rd_valid_nxt = (w_state_nxt == RUN) && (w_cur_lin_nxt < w_wr_count_nxt);
        w_rd_last_nxt  = w_rd_valid_nxt && (w_c_nxt == C_C_MAX)
                         && (w_kw_nxt == C_K_MAX) && (w_kh_nxt == C_K_MAX);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_wr_count   <= '0;
            r_rel_count  <= '0;
            r_cur_lin    <= '0;
            r_row_lin    <= '0;
            r_win_lin    <= '0;
            r_wrow_lin   <= '0;
            r_c          <= '0;
            r_kw         <= '0;
            r_kh         <= '0;
            r_ox         <= '0;
            r_oy         <= '0;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_row_addr   <= '0;
            r_win_addr   <= '0;
            r_wrow_addr  <= '0;
            r_wr_ready   <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_count   <= w_wr_count_nxt;
            r_rel_count  <= w_rel_count_nxt;
            r_cur_lin    <= w_cur_lin_nxt;
            r_row_lin    <= w_row_lin_nxt;
            r_win_lin    <= w_win_lin_nxt;
            r_wrow_lin   <= w_wrow_lin_nxt;
            r_c          <= w_c_nxt;
            r_kw         <= w_kw_nxt;
            r_kh         <= w_kh_nxt;
            r_ox         <= w_ox_nxt;
            r_oy         <= w_oy_nxt;
            r_wr_addr    <= w_wr_addr_nxt;
            r_rd_addr    <= w_rd_addr_nxt;
            r_row_addr   <= w_row_addr_nxt;
            r_win_addr   <= w_win_addr_nxt;
            r_wrow_addr  <= w_wrow_addr_nxt;
            r_wr_ready   <= w_wr_ready_nxt;
            r_rd_valid   <= w_rd_valid_nxt;
            r_rd_last    <= w_rd_last_nxt;
            r_busy       <= (w_state_nxt != IDLE);
            r_frame_done <= (w_state_nxt == DONE);
        end
    end

    assign wr_ready   = r_wr_ready;
    assign wr_addr    = r_wr_addr;
    assign rd_valid   = r_rd_valid;
    assign rd_addr    = r_rd_addr;
    assign rd_last    = r_rd_last;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

`ifdef SWU_SCHED_STATS_EN
    logic [31:0] r_stat_rd_starve;
    logic [31:0] r_stat_wr_block;

    // Saturating stall counters, cleared when a new frame starts
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stat_rd_starve <= '0;
            r_stat_wr_block  <= '0;
        end else if (r_state == IDLE && start) begin
            r_stat_rd_starve <= '0;
            r_stat_wr_block  <= '0;
        end else begin
            if (r_state == RUN && !(r_cur_lin < r_wr_count) && r_stat_rd_starve != '1) begin
                r_stat_rd_starve <= r_stat_rd_starve + 32'd1;
            end
            if ((r_state == RUN || r_state == FLUSH) && wr_valid && !r_wr_ready
                && r_stat_wr_block != '1) begin
                r_stat_wr_block <= r_stat_wr_block + 32'd1;
            end
        end
    end

    assign stat_rd_starve = r_stat_rd_starve;
    assign stat_wr_block  = r_stat_wr_block;
`endif

endmodule

// File: tb/tb_swu_window_scheduler.sv
// Directed bench for swu_window_scheduler: default geometry DUT plus a stride-2 DUT.
module tb_swu_window_scheduler;
    import swu_sched_pkg::*;

    localparam int unsigned AW = 6;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic          a_start, a_wr_valid, a_rd_ready;
    logic          a_wr_ready, a_rd_valid, a_rd_last, a_busy, a_frame_done;
    logic [AW-1:0] a_wr_addr, a_rd_addr;
    logic          b_start, b_wr_valid, b_rd_ready;
    logic          b_wr_ready, b_rd_valid, b_rd_last, b_busy, b_frame_done;
    logic [AW-1:0] b_wr_addr, b_rd_addr;
`ifdef SWU_SCHED_STATS_EN
    logic [31:0]   a_stat_rd_starve, a_stat_wr_block, b_stat_rd_starve, b_stat_wr_block;
`endif

    int checks = 0;
    int errors = 0;
    int a_wr_fires, a_rd_fires, a_last_fires, a_done_cnt;
    int b_wr_fires, b_rd_fires, b_done_cnt;
    logic [AW-1:0] a_last_wr_addr, a_last_rd_addr;
    logic          a_last_rd_last;
    bit            model_on, b_tail;

    swu_window_scheduler dut_a (
        .clk(clk), .resetn(resetn), .start(a_start),
        .wr_valid(a_wr_valid), .wr_ready(a_wr_ready), .wr_addr(a_wr_addr),
        .rd_valid(a_rd_valid), .rd_ready(a_rd_ready), .rd_addr(a_rd_addr),
        .rd_last(a_rd_last), .busy(a_busy), .frame_done(a_frame_done)
`ifdef SWU_SCHED_STATS_EN
        , .stat_rd_starve(a_stat_rd_starve), .stat_wr_block(a_stat_wr_block)
`endif
    );

    swu_window_scheduler #(.OFM_DIM(3), .STRIDE(2)) dut_b (
        .clk(clk), .resetn(resetn), .start(b_start),
        .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_addr(b_wr_addr),
        .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_addr(b_rd_addr),
        .rd_last(b_rd_last), .busy(b_busy), .frame_done(b_frame_done)
`ifdef SWU_SCHED_STATS_EN
        , .stat_rd_starve(b_stat_rd_starve), .stat_wr_block(b_stat_wr_block)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference read order for the default geometry: c, kw, kh, ox, oy
    function automatic logic [63:0] exp_addr(input int idx);
        int c, kw, kh, w, ox, oy, lin;
        c   = idx % DEF_FOLD;
        kw  = (idx / DEF_FOLD) % DEF_K;
        kh  = (idx / (DEF_FOLD * DEF_K)) % DEF_K;
        w   = idx / (DEF_FOLD * DEF_K * DEF_K);
        ox  = w % DEF_OFM_DIM;
        oy  = w / DEF_OFM_DIM;
        lin = ((oy * DEF_STRIDE + kh) * DEF_IFM_DIM + ox * DEF_STRIDE + kw) * DEF_FOLD + c;
        return 64'(lin % DEF_BUF_DEPTH);
    endfunction

    function automatic logic [63:0] exp_last(input int idx);
        return 64'((idx % (DEF_FOLD * DEF_K * DEF_K)) == (DEF_FOLD * DEF_K * DEF_K - 1));
    endfunction

    // Advance one clock, recording handshakes presented just before the edge
    task automatic tick();
        if (a_wr_valid && a_wr_ready) begin
            a_wr_fires++;
            a_last_wr_addr = a_wr_addr;
        end
        if (a_rd_valid && a_rd_ready) begin
            if (model_on) begin
                check("rd_addr_model", a_rd_addr, exp_addr(a_rd_fires));
                check("rd_last_model", a_rd_last, exp_last(a_rd_fires));
            end
            a_rd_fires++;
            a_last_rd_addr = a_rd_addr;
            a_last_rd_last = a_rd_last;
            if (a_rd_last) a_last_fires++;
        end
        if (b_wr_valid && b_wr_ready) begin
            if (b_tail) check("t5_tail_rd_valid", b_rd_valid, 0);
            b_wr_fires++;
        end
        if (b_rd_valid && b_rd_ready) b_rd_fires++;
        @(posedge clk);
        #1;
        if (a_frame_done) a_done_cnt++;
        if (b_frame_done) b_done_cnt++;
    endtask

    task automatic run_frame_a(input string tag);
        a_wr_fires = 0; a_rd_fires = 0; a_last_fires = 0; a_done_cnt = 0;
        model_on = 1'b1;
        a_start = 1'b1; a_wr_valid = 1'b0; a_rd_ready = 1'b0;
        tick();
        a_start = 1'b0;
        check({tag, "_start_busy"}, a_busy, 1);
        check({tag, "_start_rd_addr"}, a_rd_addr, 0);
        for (int i = 0; i < 20000 && a_done_cnt == 0; i++) begin
            a_wr_valid = 1'($urandom_range(0, 1));
            a_rd_ready = 1'($urandom_range(0, 1));
            tick();
        end
        model_on = 1'b0; a_wr_valid = 1'b0; a_rd_ready = 1'b0;
        check({tag, "_done_seen"}, a_done_cnt, 1);
        check({tag, "_rd_fires"}, a_rd_fires, TOTAL_BEATS);
        check({tag, "_wr_fires"}, a_wr_fires, TOTAL_IN);
        check({tag, "_windows"}, a_last_fires, DEF_OFM_DIM * DEF_OFM_DIM);
        tick();
        check({tag, "_busy_after"}, a_busy, 0);
        check({tag, "_done_pulse_width"}, a_frame_done, 0);
        check({tag, "_done_once"}, a_done_cnt, 1);
    endtask

    initial begin
        resetn = 1'b0;
        a_start = 1'b0; a_wr_valid = 1'b0; a_rd_ready = 1'b0;
        b_start = 1'b0; b_wr_valid = 1'b0; b_rd_ready = 1'b0;
        a_wr_fires = 0; a_rd_fires = 0; a_last_fires = 0; a_done_cnt = 0;
        b_wr_fires = 0; b_rd_fires = 0; b_done_cnt = 0;
        a_last_wr_addr = '0; a_last_rd_addr = '0; a_last_rd_last = 1'b0;
        model_on = 1'b0; b_tail = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_ready", a_wr_ready, 0);
        check("rst_rd_valid", a_rd_valid, 0);
        check("rst_rd_last", a_rd_last, 0);
        check("rst_busy", a_busy, 0);
        check("rst_frame_done", a_frame_done, 0);
        check("rst_wr_addr", a_wr_addr, 0);
        check("rst_rd_addr", a_rd_addr, 0);
        check("rst_b_busy", b_busy, 0);
        resetn = 1'b1;
        tick();
        check("idle_no_start", a_busy, 0);

        // Fill with reads stalled
        a_start = 1'b1; a_wr_valid = 1'b1;
        tick();
        a_start = 1'b0;
        check("t1_busy", a_busy, 1);
        check("t1_wr_ready", a_wr_ready, 1);
        check("t1_rd_valid_empty", a_rd_valid, 0);
        tick();
        check("t1_first_write", a_wr_fires, 1);
        check("t1_rd_valid", a_rd_valid, 1);
        check("t1_rd_addr", a_rd_addr, 0);
        check("t1_wr_addr", a_wr_addr, 1);
        for (int i = 0; i < 200 && a_wr_ready; i++) tick();
        check("t1_writes", a_wr_fires, 64);
        check("t1_wr_ready_full", a_wr_ready, 0);
        check("t1_last_wr_addr", a_last_wr_addr, 63);
        check("t1_wr_addr_wrap", a_wr_addr, 0);
        repeat (3) tick();
        check("t1_hold", a_wr_fires, 64);

        // First window drains, release of two elements
        a_rd_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            automatic bit last_pending = a_rd_valid && a_rd_last;
            tick();
            if (last_pending) break;
        end
        a_rd_ready = 1'b0;
        check("t2_beats", a_rd_fires, 18);
        check("t2_last_count", a_last_fires, 1);
        check("t2_last_addr", a_last_rd_addr, 37);
        check("t2_rel_count", dut_a.r_rel_count, 2);
        check("t2_wr_ready_back", a_wr_ready, 1);
        check("t2_next_rd_addr", a_rd_addr, 2);
        tick();
        check("t2_wr_addr0", a_last_wr_addr, 0);
        tick();
        check("t2_wr_addr1", a_last_wr_addr, 1);
        check("t2_writes", a_wr_fires, 66);
        check("t2_wr_ready_full", a_wr_ready, 0);

        // Row wrap from window (0,5) into (1,0)
        a_rd_ready = 1'b1;
        for (int i = 0; i < 1000 && a_rd_fires < 108; i++) tick();
        a_rd_ready = 1'b0;
        check("t3_beats", a_rd_fires, 108);
        check("t3_last_addr", a_last_rd_addr, 47);
        check("t3_last_flag", a_last_rd_last, 1);
        check("t3_rel_count", dut_a.r_rel_count, 16);
        check("t3_rd_valid", a_rd_valid, 1);
        check("t3_next_rd_addr", a_rd_addr, 16);

        // Stride 2: uncovered last row/column accepted in FLUSH
        a_wr_valid = 1'b0;
        b_start = 1'b1; b_wr_valid = 1'b1; b_rd_ready = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 2000 && b_wr_fires < 110; i++) tick();
        b_wr_valid = 1'b0;
        check("t5_pre_writes", b_wr_fires, 110);
        for (int i = 0; i < 2000 && b_rd_fires < 162; i++) tick();
        tick();
        tick();
        check("t5_reads", b_rd_fires, 162);
        check("t5_flush_busy", b_busy, 1);
        check("t5_flush_rd_valid", b_rd_valid, 0);
        check("t5_flush_wr_ready", b_wr_ready, 1);
        check("t5_no_early_done", b_done_cnt, 0);
        b_tail = 1'b1; b_wr_valid = 1'b1;
        for (int i = 0; i < 200 && b_done_cnt == 0; i++) tick();
        b_tail = 1'b0; b_wr_valid = 1'b0;
        check("t5_done_pulse", b_done_cnt, 1);
        check("t5_total_writes", b_wr_fires, 128);
        tick();
        check("t5_busy_after", b_busy, 0);

        // Asynchronous reset in the middle of a window (kh == 1)
        a_wr_valid = 1'b1; a_rd_ready = 1'b1;
        for (int i = 0; i < 200 && dut_a.r_kh != 2'd1; i++) tick();
        check("t6_kh_reached", dut_a.r_kh, 1);
        #2 resetn = 1'b0;
        #1;
        check("t6_rst_wr_ready", a_wr_ready, 0);
        check("t6_rst_rd_valid", a_rd_valid, 0);
        check("t6_rst_rd_last", a_rd_last, 0);
        check("t6_rst_busy", a_busy, 0);
        check("t6_rst_frame_done", a_frame_done, 0);
        check("t6_rst_wr_addr", a_wr_addr, 0);
        check("t6_rst_rd_addr", a_rd_addr, 0);
        a_wr_valid = 1'b0; a_rd_ready = 1'b0;
        tick();
        resetn = 1'b1;
        tick();

        run_frame_a("frame_after_reset");
        run_frame_a("frame_replay");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
